instruction_fetch_unit: RTL and testbench

IF-stage requester for the byte-addressed, little-endian, combinational-read instruction memory. It holds the PC and drives Inst_Address, then captures the returned 32-bit Instruction into the IF/ID pipeline register. It handles stall, branch redirect with bubble insertion, running off the end of memory, and misaligned-target faults. It sits between the hazard/branch logic in EX and the decode stage.

---
 rtl/instruction_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//   IF-stage requester for a byte-addressed, combinational-read instruction
//   memory. It holds the PC, drives it straight out as Inst_Address, and
//   captures the returned word into the IF/ID pipeline register. It also
//   handles stall, branch redirect (with bubble), run-off past the end of
//   memory (HALT) and misaligned redirect targets (sticky FAULT).
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   stall              : hold PC / IF/ID / fetch_count
//   branch_taken       : redirect request from EX
//   branch_target[63:0]: redirect byte address
//   Instruction[31:0]  : word read at Inst_Address (same cycle)
//   Inst_Address[63:0] : fetch address (= PC register)
//   if_id_pc/_instruction/_valid : IF/ID pipeline register
//   halted             : fetch stopped, PC past the last legal word
//   fault              : sticky misaligned-redirect flag
//   fetch_count[31:0]  : delivered-instruction count, saturating
// ----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int          IMEM_BYTES = 88,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic [31:0] Instruction,
    output logic [63:0] Inst_Address,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam logic [63:0] LAST_ADDR = 64'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_t;

    state_t      r_state, w_state_nxt;
    logic [63:0] r_pc;
    logic [63:0] r_if_id_pc;
    logic [31:0] r_if_id_inst;
    logic        r_if_id_valid;
    logic [31:0] r_fetch_count;

    logic        w_aligned;
    logic        w_in_range;
    logic        w_redirect;   // PC <= branch_target
    logic        w_capture;    // IF/ID <= real instruction, PC += 4
    logic        w_bubble;     // IF/ID <= NOP bubble

    assign w_aligned  = (branch_target[1:0] == 2'b00);
    // Range check is done on the PC at fetch time, never on the target.
    assign w_in_range = (r_pc <= LAST_ADDR);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_RUN;
        else       r_state <= w_state_nxt;
    end

    // ---------------- next-state / datapath control ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_redirect  = 1'b0;
        w_capture   = 1'b0;
        w_bubble    = 1'b0;
        case (r_state)
            S_RUN: begin
                if (branch_taken) begin
                    // Redirect overrides stall; the wrong-path word is dropped.
                    w_bubble = 1'b1;
                    if (w_aligned) w_redirect  = 1'b1;
                    else           w_state_nxt = S_FAULT;
                end else if (stall) begin
                    // hold everything
                end else if (w_in_range) begin
                    w_capture = 1'b1;
                end else begin
                    w_bubble    = 1'b1;
                    w_state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                w_bubble = 1'b1;
                if (branch_taken) begin
                    if (w_aligned) begin
                        w_redirect  = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_FAULT;
                    end
                end
            end
            default: begin
                w_bubble = 1'b1;
            end
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        halted = (r_state == S_HALT);
        fault  = (r_state == S_FAULT);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_if_id_pc    <= 64'd0;
            r_if_id_inst  <= NOP_INST;
            r_if_id_valid <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            if (w_redirect)     r_pc <= branch_target;
            else if (w_capture) r_pc <= r_pc + 64'd4;

            if (w_capture) begin
                r_if_id_pc    <= r_pc;
                r_if_id_inst  <= Instruction;
                r_if_id_valid <= 1'b1;
                if (r_fetch_count != 32'hFFFF_FFFF)
                    r_fetch_count <= r_fetch_count + 32'd1;
            end else if (w_bubble) begin
                r_if_id_pc    <= 64'd0;
                r_if_id_inst  <= NOP_INST;
                r_if_id_valid <= 1'b0;
            end
        end
    end

    assign Inst_Address      = r_pc;
    assign if_id_pc          = r_if_id_pc;
    assign if_id_instruction = r_if_id_inst;
    assign if_id_valid       = r_if_id_valid;
    assign fetch_count       = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [31:0] Instruction;
    logic [63:0] Inst_Address;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [31:0] mem [0:21];

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .RESET_PC  (64'd0),
        .IMEM_BYTES(88),
        .NOP_INST  (32'h0000_0013)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .Instruction      (Instruction),
        .Inst_Address     (Inst_Address),
        .if_id_pc         (if_id_pc),
        .if_id_instruction(if_id_instruction),
        .if_id_valid      (if_id_valid),
        .halted           (halted),
        .fault            (fault),
        .fetch_count      (fetch_count)
    );

    // Combinational instruction memory; garbage outside the array.
    always_comb begin
        Instruction = 32'hDEAD_BEEF;
        if (Inst_Address < 64'd88) Instruction = mem[Inst_Address[6:2]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // mem[i] = addi x1,x0,i except the words the plan fixes
        for (int i = 0; i < 22; i++) mem[i] = 32'h0000_0093 + (32'(i) << 20);
        mem[0]  = 32'h0000_0913;
        mem[1]  = 32'h0000_0433;
        mem[15] = 32'h01a0_02b3;

        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'd0;
        step();
        chk("rst_addr",  Inst_Address, 64'd0);
        chk("rst_valid", if_id_valid, 1'b0);
        chk("rst_inst",  if_id_instruction, 32'h13);
        chk("rst_pc",    if_id_pc, 64'd0);
        chk("rst_halt",  halted, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_cnt",   fetch_count, 32'd0);

        // sequential fetch
        reset = 1'b0;
        step();
        chk("e1_pc",    if_id_pc, 64'd0);
        chk("e1_inst",  if_id_instruction, 32'h0000_0913);
        chk("e1_valid", if_id_valid, 1'b1);
        step();
        chk("e2_pc",    if_id_pc, 64'd4);
        chk("e2_inst",  if_id_instruction, 32'h0000_0433);
        chk("e2_cnt",   fetch_count, 32'd2);
        chk("e2_addr",  Inst_Address, 64'd8);

        // stall 3 cycles at PC=8
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stl_pc",   if_id_pc, 64'd4);
            chk("stl_inst", if_id_instruction, 32'h0000_0433);
            chk("stl_addr", Inst_Address, 64'd8);
            chk("stl_cnt",  fetch_count, 32'd2);
        end
        stall = 1'b0;
        step();
        chk("rel_pc",   if_id_pc, 64'd8);
        chk("rel_inst", if_id_instruction, 32'h0020_0093);
        chk("rel_cnt",  fetch_count, 32'd3);
        step();  // captures 0x0C, PC -> 0x10
        chk("pc10_addr", Inst_Address, 64'h10);

        // redirect while stalled
        branch_taken = 1'b1; branch_target = 64'h3C; stall = 1'b1;
        step();
        chk("br_valid", if_id_valid, 1'b0);
        chk("br_inst",  if_id_instruction, 32'h13);
        chk("br_addr",  Inst_Address, 64'h3C);
        chk("br_cnt",   fetch_count, 32'd4);
        branch_taken = 1'b0; stall = 1'b0;
        step();
        chk("tgt_pc",    if_id_pc, 64'h3C);
        chk("tgt_inst",  if_id_instruction, 32'h01a0_02b3);
        chk("tgt_valid", if_id_valid, 1'b1);

        // run to the end of memory: 0x40..0x54
        for (int k = 0; k < 6; k++) step();
        chk("end_pc",    if_id_pc, 64'h54);
        chk("end_inst",  if_id_instruction, 32'h0150_0093);
        chk("end_valid", if_id_valid, 1'b1);
        chk("end_cnt",   fetch_count, 32'd11);
        step();
        chk("hlt_flag",  halted, 1'b1);
        chk("hlt_valid", if_id_valid, 1'b0);
        chk("hlt_addr",  Inst_Address, 64'h58);
        stall = 1'b1;
        step();
        chk("hlt2_flag", halted, 1'b1);
        chk("hlt2_addr", Inst_Address, 64'h58);
        chk("hlt2_cnt",  fetch_count, 32'd11);
        stall = 1'b0;

        // recover from HALT
        branch_taken = 1'b1; branch_target = 64'h0C;
        step();
        chk("rec_halt",  halted, 1'b0);
        chk("rec_addr",  Inst_Address, 64'h0C);
        chk("rec_valid", if_id_valid, 1'b0);
        branch_taken = 1'b0;
        step();
        chk("rec_pc",    if_id_pc, 64'h0C);
        chk("rec_inst",  if_id_instruction, 32'h0030_0093);
        chk("rec_cnt",   fetch_count, 32'd12);

        // misaligned redirect from RUN (PC=0x10)
        branch_taken = 1'b1; branch_target = 64'h42;
        step();
        chk("flt_flag",  fault, 1'b1);
        chk("flt_valid", if_id_valid, 1'b0);
        chk("flt_addr",  Inst_Address, 64'h10);
        branch_target = 64'h20;
        step();
        chk("flt2_flag", fault, 1'b1);
        chk("flt2_addr", Inst_Address, 64'h10);
        branch_taken = 1'b0;
        step();
        chk("flt3_addr", Inst_Address, 64'h10);
        chk("flt3_cnt",  fetch_count, 32'd12);

        // reset beats a simultaneous redirect
        reset = 1'b1; branch_taken = 1'b1; branch_target = 64'h20;
        step();
        chk("rb_addr",  Inst_Address, 64'd0);
        chk("rb_fault", fault, 1'b0);
        chk("rb_valid", if_id_valid, 1'b0);
        chk("rb_inst",  if_id_instruction, 32'h13);
        chk("rb_cnt",   fetch_count, 32'd0);
        reset = 1'b0; branch_taken = 1'b0;
        step();
        chk("rb2_pc",  if_id_pc, 64'd0);
        chk("rb2_cnt", fetch_count, 32'd1);

        // aligned redirect out of range: RUN one cycle, then HALT
        branch_taken = 1'b1; branch_target = 64'h60;
        step();
        chk("oor_addr", Inst_Address, 64'h60);
        chk("oor_halt", halted, 1'b0);
        branch_taken = 1'b0;
        step();
        chk("oor2_halt",  halted, 1'b1);
        chk("oor2_valid", if_id_valid, 1'b0);
        chk("oor2_cnt",   fetch_count, 32'd1);

        // misaligned redirect from HALT
        branch_taken = 1'b1; branch_target = 64'h43;
        step();
        chk("hf_fault", fault, 1'b1);
        chk("hf_halt",  halted, 1'b0);
        chk("hf_addr",  Inst_Address, 64'h60);
        branch_taken = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
